// File: rtl/window_assembler.sv
// Assembles a 3x3 image window and a 3x3 kernel from a memory word stream.
// The kernel stays resident, and a new scope may be loaded once the downstream has taken the window.
module window_assembler #(
  parameter int dataSize = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              OPCODE,
  input  logic [dataSize-1:0]     mem_data,
  input  logic                    mem_valid,
  input  logic                    out_ready,
  output logic [9*dataSize-1:0]   scope_flat,
  output logic [9*dataSize-1:0]   kernel_flat,
  output logic                    out_valid,
  output logic                    busy,
  output logic [3:0]              index
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    FILL_SCOPE  = 2'd1,
    FILL_KERNEL = 2'd2
  } state_t;

  state_t state;
  logic   scope_full;
  logic   kernel_full;
  logic   handshake;
  logic   start_scope;
  logic   start_kernel;
  logic   last_write;
  logic   scope_full_nx;
  logic   kernel_full_nx;

  // A handshake frees the scope in the same cycle, so a scope load may start on it.
  always_comb begin
    handshake      = out_valid && out_ready;
    start_scope    = (state == IDLE) && (OPCODE == 2'b01) && !(scope_full && !handshake);
    start_kernel   = (state == IDLE) && (OPCODE == 2'b10) && !out_valid;
    last_write     = (state != IDLE) && mem_valid && (index == 4'd8);
    scope_full_nx  = (scope_full && !handshake) || (last_write && (state == FILL_SCOPE));
    kernel_full_nx = (kernel_full && !start_kernel) || (last_write && (state == FILL_KERNEL));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      index       <= 4'd0;
      scope_full  <= 1'b0;
      kernel_full <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      scope_flat  <= '0;
      kernel_flat <= '0;
    end else begin
      scope_full  <= scope_full_nx;
      kernel_full <= kernel_full_nx;
      out_valid   <= scope_full_nx && kernel_full_nx;
      case (state)
        IDLE: begin
          index <= 4'd0;
          if (start_scope) begin
            state <= FILL_SCOPE;
            busy  <= 1'b1;
          end else if (start_kernel) begin
            state <= FILL_KERNEL;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        FILL_SCOPE, FILL_KERNEL: begin
          if (mem_valid) begin
            for (int k = 0; k < 9; k++) begin
              if (index == 4'(k)) begin
                if (state == FILL_SCOPE) begin
                  scope_flat[k*dataSize +: dataSize] <= mem_data;
                end else begin
                  kernel_flat[k*dataSize +: dataSize] <= mem_data;
                end
              end
            end
            if (last_write) begin
              index <= 4'd0;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              index <= index + 4'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          index <= 4'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/window_assembler.md
WINDOW_ASSEMBLER -- requirements
Module: window_assembler

Interface
REQ-001 Parameter: dataSize, default 8, width of one pixel/weight word returned by image memory.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 OPCODE  input  2  00 NOOP, 01 LOAD SCOPE, 10 LOAD KERNEL, 11 NOOP (reserved).
REQ-005 mem_data  input  dataSize  word read from image memory for the most recently issued address.
REQ-006 mem_valid  input  1  mem_data valid this cycle.
REQ-007 out_ready  input  1  downstream MAC accepts the current window.
REQ-008 scope_flat  output  9*dataSize  3x3 image window, slot k at bits [k*dataSize +: dataSize].
REQ-009 kernel_flat  output  9*dataSize  3x3 kernel weights, same slot layout.
REQ-010 out_valid  output  1  scope and kernel both complete and held stable.
REQ-011 busy  output  1  high while in FILL_SCOPE or FILL_KERNEL.
REQ-012 index  output  4  next slot to be written (0..8).

Function
REQ-013 FSM states SHALL be IDLE, FILL_SCOPE, FILL_KERNEL; OPCODE SHALL be sampled only in IDLE.
REQ-014 Slot order SHALL be row-major: slot 0 top-left, 2 top-right, 3 middle-left, 8 bottom-right, matching the address order n, n+1, n+2, n+m, ..., n+2m+2.
REQ-015 IDLE, OPCODE=01, scope_full=0 (after handshake term, REQ-021): next state FILL_SCOPE, index<=0, scope_full<=0.
REQ-016 IDLE, OPCODE=10, out_valid=0: next state FILL_KERNEL, index<=0, kernel_full<=0.
REQ-017 OPCODE 01 with scope_full=1, OPCODE 10 with out_valid=1, and OPCODE 00/11 SHALL be ignored (stay IDLE, no state change).
REQ-018 In FILL_*, each cycle with mem_valid=1 SHALL write mem_data into slot index of the active buffer and increment index; mem_valid=0 cycles SHALL hold everything.
REQ-019 Write of slot 8 SHALL set the active buffer's full flag, reset index to 0, return to IDLE in the same edge.
REQ-020 out_valid SHALL be registered = scope_full & kernel_full, asserting the cycle after the final slot-8 write of whichever buffer completes last.
REQ-021 out_valid & out_ready SHALL clear scope_full only; kernel persists and is reused for subsequent windows.
REQ-022 Handshake and OPCODE=01 in the same IDLE cycle SHALL be accepted: scope freed and FILL_SCOPE entered on that edge.
REQ-023 mem_valid in IDLE SHALL be ignored; OPCODE changes during FILL_* SHALL be ignored.
REQ-024 scope_flat/kernel_flat SHALL not change while the corresponding full flag is set.
REQ-025 index SHALL never exceed 8; no wrap beyond slot 8.

Reset
REQ-026 rst=1 at posedge SHALL force IDLE, index=0, scope_full=kernel_full=0, out_valid=0, busy=0, both buffers all-zero, regardless of state (incl. mid-fill).
REQ-027 rst SHALL take priority over OPCODE, mem_valid and out_ready in the same cycle.

Verification
REQ-028 Kernel load: OPCODE=10, then 9 mem_valid words 1..9 -> kernel_flat slots 0..8 = 1..9, busy high 9 cycles, out_valid stays 0.
REQ-029 Scope after kernel: OPCODE=01, words 0x10..0x18 with mem_valid gaps -> out_valid=1 one cycle after 0x18 written; scope slot 4 = 0x14.
REQ-030 Backpressure: out_ready=0 for 5 cycles with OPCODE=01 held -> FSM stays IDLE, outputs stable; out_ready=1 with OPCODE=01 -> out_valid drops next cycle, busy=1, kernel_flat unchanged.
REQ-031 Kernel reload blocked: out_valid=1, OPCODE=10 -> ignored, kernel_flat unchanged.
REQ-032 Reset mid-fill: rst after 4 scope words -> index=0, scope_flat=0, busy=0; subsequent full load of 9 words fills slots 0..8 correctly.
REQ-033 Stray data: mem_valid=1 in IDLE with 0xFF -> no buffer change, index stays 0.
